// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - priority scheduler that sequences sound-effect tone envelopes onto one piezo
module sfx_scheduler #(
   parameter int HALF_PERFECT = 23_900,
   parameter int HALF_GOOD    = 31_888,
   parameter int HALF_MISS    = 113_636,
   parameter int DUR_PERFECT  = 2_500_000,
   parameter int DUR_GOOD     = 5_000_000,
   parameter int DUR_MISS     = 10_000_000,
   parameter int GAP_CYC      = 1_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [1:0] i_Sound_Cmd,
   input  logic       i_Mute,
   output logic       o_Piezo,
   output logic       o_Busy,
   output logic [1:0] o_Active_Cmd,
   output logic [7:0] o_Drop_Cnt
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int HW = $clog2(max2(HALF_MISS, max2(HALF_GOOD, HALF_PERFECT)) + 1);
   localparam int DW = $clog2(max2(max2(DUR_MISS, DUR_GOOD), max2(DUR_PERFECT, GAP_CYC)) + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEG1, S_SEG2, S_GAP} state_t;

   // Miss beats Perfect beats Good; 0 (no effect) ranks lowest
   function automatic logic [1:0] prio(input logic [1:0] c);
      case (c)
         2'd3:    return 2'd3;
         2'd1:    return 2'd2;
         2'd2:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   state_t          r_state, w_state;
   logic [1:0]      r_cur, w_cur;
   logic [1:0]      r_pend, w_pend;
   logic [HW-1:0]   r_half, w_half;
   logic [DW-1:0]   r_dur, w_dur;
   logic            r_tone, w_tone;
   logic [7:0]      r_drop, w_drop;

   logic [HW-1:0]   w_half_lim;
   logic [DW-1:0]   w_dur_lim;
   logic            w_in_seg;
   logic            w_seg_end;
   logic            w_gap_end;
   logic            w_start;
   logic [1:0]      w_start_cmd;
   logic            w_drop_inc;

   always_comb begin
      w_half_lim = HW'(HALF_MISS - 1);
      if (r_cur == 2'd1 && r_state == S_SEG2)
         w_half_lim = HW'(HALF_PERFECT - 1);
      else if (r_cur == 2'd1 || r_cur == 2'd2)
         w_half_lim = HW'(HALF_GOOD - 1);

      w_dur_lim = DW'(DUR_MISS - 1);
      if (r_state == S_GAP)
         w_dur_lim = DW'(GAP_CYC - 1);
      else if (r_cur == 2'd1)
         w_dur_lim = DW'(DUR_PERFECT - 1);
      else if (r_cur == 2'd2)
         w_dur_lim = DW'(DUR_GOOD - 1);
   end

   assign w_in_seg  = (r_state == S_SEG1) || (r_state == S_SEG2);
   assign w_seg_end = w_in_seg && (r_dur == w_dur_lim);
   assign w_gap_end = (r_state == S_GAP) && (r_dur == w_dur_lim);

   always_comb begin
      w_state     = r_state;
      w_cur       = r_cur;
      w_pend      = r_pend;
      w_half      = r_half;
      w_dur       = r_dur;
      w_tone      = r_tone;
      w_start     = 1'b0;
      w_start_cmd = 2'd0;
      w_drop_inc  = 1'b0;

      if (w_in_seg) begin
         w_dur = r_dur + 1'b1;
         if (r_half == w_half_lim) begin
            w_half = '0;
            w_tone = ~r_tone;
         end else begin
            w_half = r_half + 1'b1;
         end
      end else if (r_state == S_GAP) begin
         w_dur = r_dur + 1'b1;
      end

      // Arbitration runs first so a segment end below sees the updated pending entry
      if (i_Sound_Cmd != 2'd0) begin
         case (r_state)
            S_IDLE: begin
               w_start     = 1'b1;
               w_start_cmd = i_Sound_Cmd;
            end
            S_SEG1, S_SEG2: begin
               if (prio(i_Sound_Cmd) >= prio(r_cur)) begin
                  w_start     = 1'b1;
                  w_start_cmd = i_Sound_Cmd;
                  w_drop_inc  = 1'b1;
               end else if (r_pend == 2'd0 || prio(i_Sound_Cmd) > prio(r_pend)) begin
                  w_pend     = i_Sound_Cmd;
                  w_drop_inc = (r_pend != 2'd0);
               end else begin
                  w_drop_inc = 1'b1;
               end
            end
            default: begin
               if (prio(i_Sound_Cmd) >= prio(r_pend))
                  w_pend = i_Sound_Cmd;
               w_drop_inc = 1'b1;
            end
         endcase
      end

      if (!w_start && w_gap_end) begin
         w_start     = 1'b1;
         w_start_cmd = w_pend;
         w_pend      = 2'd0;
      end else if (!w_start && w_seg_end) begin
         w_half = '0;
         w_dur  = '0;
         if (r_state == S_SEG1 && r_cur == 2'd1) begin
            w_state = S_SEG2;
            w_tone  = 1'b1;
         end else begin
            w_state = (w_pend != 2'd0) ? S_GAP : S_IDLE;
            w_cur   = 2'd0;
            w_tone  = 1'b0;
         end
      end

      if (w_start) begin
         w_state = S_SEG1;
         w_cur   = w_start_cmd;
         w_half  = '0;
         w_dur   = '0;
         w_tone  = 1'b1;
      end

      w_drop = (w_drop_inc && r_drop != 8'hFF) ? r_drop + 8'd1 : r_drop;
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_state <= S_IDLE;
         r_cur   <= 2'd0;
         r_pend  <= 2'd0;
         r_half  <= '0;
         r_dur   <= '0;
         r_tone  <= 1'b0;
         r_drop  <= 8'd0;
      end else begin
         r_state <= w_state;
         r_cur   <= w_cur;
         r_pend  <= w_pend;
         r_half  <= w_half;
         r_dur   <= w_dur;
         r_tone  <= w_tone;
         r_drop  <= w_drop;
      end
   end

   assign o_Piezo      = r_tone & ~i_Mute;
   assign o_Busy       = (r_state != S_IDLE);
   assign o_Active_Cmd = r_cur;
   assign o_Drop_Cnt   = r_drop;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - directed scoreboard bench for sfx_scheduler
module tb_sfx_scheduler;

   logic       i_Clk = 1'b0;
   logic       i_Rst = 1'b0;
   logic [1:0] i_Sound_Cmd = 2'd0;
   logic       i_Mute = 1'b0;
   logic       o_Piezo;
   logic       o_Busy;
   logic [1:0] o_Active_Cmd;
   logic [7:0] o_Drop_Cnt;

   sfx_scheduler #(
      .HALF_PERFECT (2),
      .HALF_GOOD    (3),
      .HALF_MISS    (5),
      .DUR_PERFECT  (12),
      .DUR_GOOD     (12),
      .DUR_MISS     (20),
      .GAP_CYC      (4)
   ) dut (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Sound_Cmd  (i_Sound_Cmd),
      .i_Mute       (i_Mute),
      .o_Piezo      (o_Piezo),
      .o_Busy       (o_Busy),
      .o_Active_Cmd (o_Active_Cmd),
      .o_Drop_Cnt   (o_Drop_Cnt)
   );

   always #5 i_Clk = ~i_Clk;

   // One entry per cycle: inputs to drive and the {piezo, busy, active} expected during that cycle
   typedef struct {
      logic [1:0] cmd;
      logic       mute;
      logic [3:0] exp;
   } step_t;

   step_t sb[$];
   int    checks = 0;
   int    errors = 0;
   string scen;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] cmd, input logic [3:0] exp);
      step_t s;
      s.cmd  = cmd;
      s.mute = 1'b0;
      s.exp  = exp;
      sb.push_back(s);
   endtask

   task automatic push_seg(input int half, input int dur, input logic [1:0] act);
      for (int i = 0; i < dur; i++)
         push(2'd0, {((i / half) % 2) == 0, 1'b1, act});
   endtask

   task automatic push_gap(input int n);
      for (int i = 0; i < n; i++)
         push(2'd0, 4'b0100);
   endtask

   task automatic set_cmd(input int idx, input logic [1:0] cmd);
      sb[idx].cmd = cmd;
   endtask

   task automatic run_sb();
      step_t s;
      int    n = 0;
      while (sb.size() > 0) begin
         s = sb.pop_front();
         i_Sound_Cmd = s.cmd;
         i_Mute      = s.mute;
         #1;
         chk($sformatf("%s_cyc%0d", scen, n), {8'd0, o_Piezo, o_Busy, o_Active_Cmd},
             {8'd0, s.exp});
         @(negedge i_Clk);
         n++;
      end
      i_Sound_Cmd = 2'd0;
      i_Mute      = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      i_Rst = 1'b0;
      #1;
      chk(tag, {o_Piezo, o_Busy, o_Active_Cmd, o_Drop_Cnt}, 12'd0);
      @(negedge i_Clk);
      i_Rst = 1'b1;
   endtask

   initial begin
      @(negedge i_Clk);
      do_reset("reset0");

      scen = "good";
      push(2'd2, 4'b0000);
      push_seg(3, 12, 2'd2);
      push(2'd0, 4'b0000);
      push(2'd0, 4'b0000);
      run_sb();
      chk("good_drop", {4'd0, o_Drop_Cnt}, 12'd0);

      scen = "perfect";
      push(2'd1, 4'b0000);
      push_seg(3, 12, 2'd1);
      push_seg(2, 12, 2'd1);
      push(2'd0, 4'b0000);
      run_sb();
      chk("perfect_drop", {4'd0, o_Drop_Cnt}, 12'd0);

      do_reset("reset1");
      scen = "preempt";
      push(2'd2, 4'b0000);
      push_seg(3, 5, 2'd2);
      set_cmd(5, 2'd3);
      push_seg(5, 20, 2'd3);
      push(2'd0, 4'b0000);
      run_sb();
      chk("preempt_drop", {4'd0, o_Drop_Cnt}, 12'd1);

      do_reset("reset2");
      scen = "pending";
      push(2'd3, 4'b0000);
      push_seg(5, 20, 2'd3);
      set_cmd(3, 2'd2);
      set_cmd(6, 2'd1);
      push_gap(4);
      push_seg(3, 12, 2'd1);
      push_seg(2, 12, 2'd1);
      push(2'd0, 4'b0000);
      run_sb();
      chk("pending_drop", {4'd0, o_Drop_Cnt}, 12'd1);

      do_reset("reset3");
      scen = "mute";
      push(2'd2, 4'b0000);
      push_seg(3, 12, 2'd2);
      for (int i = 5; i <= 8; i++) begin
         sb[i].mute   = 1'b1;
         sb[i].exp[3] = 1'b0;
      end
      push(2'd0, 4'b0000);
      run_sb();
      chk("mute_drop", {4'd0, o_Drop_Cnt}, 12'd0);

      do_reset("reset4");
      scen = "saturate";
      push(2'd3, 4'b0000);
      for (int i = 1; i < 300; i++)
         push(2'd3, 4'b1111);
      push_seg(5, 8, 2'd3);
      run_sb();
      chk("sat_drop", {4'd0, o_Drop_Cnt}, 12'd255);
      chk("sat_busy", {10'd0, o_Busy, o_Piezo}, 12'd2);

      #2;
      i_Rst = 1'b0;
      #1;
      chk("async_reset", {o_Piezo, o_Busy, o_Active_Cmd, o_Drop_Cnt}, 12'd0);
      @(negedge i_Clk);
      i_Rst = 1'b1;
      @(negedge i_Clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
